mem_byte_ctrl: RTL and testbench

- Memory controller directly downstream of the memory-client arbiter.
- Consumes the arbiter's single granted request (address, width code, write enable, write data).
- Serialises each 8/16/32-bit access into little-endian byte cycles on a byte-wide synchronous SRAM.
- Returns assembled read data and a four-phase ready handshake to the arbiter.

---
 rtl/mem_byte_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mem_byte_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_ctrl.sv
// mem_byte_ctrl: serialises 8/16/32-bit arbiter accesses into byte-wide SRAM cycles.
// Define MEM_BYTE_CTRL_ALIGN_CHECK_EN to reject misaligned accesses via mem_err.
module mem_byte_ctrl #(
  parameter int         M_WIDTH     = 32,
  parameter int         RAM_A_WIDTH = 8,
  parameter logic [1:0] MEM_ACC_8   = 2'b00,
  parameter logic [1:0] MEM_ACC_16  = 2'b01,
  parameter logic [1:0] MEM_ACC_32  = 2'b10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_request,
  input  logic [M_WIDTH-1:0]     mem_addr,
  input  logic [1:0]             mem_data_width,
  input  logic                   mem_we,
  input  logic [M_WIDTH-1:0]     mem_wdata,
  output logic                   mem_ready,
  output logic [M_WIDTH-1:0]     mem_rdata,
  output logic                   mem_err,
  output logic                   ram_en,
  output logic                   ram_we,
  output logic [RAM_A_WIDTH-1:0] ram_addr,
  output logic [7:0]             ram_wdata,
  input  logic [7:0]             ram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RDLAST,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [RAM_A_WIDTH-1:0] a_lat;
  logic [31:0]            wd_lat;
  logic [31:0]            rdata_q;
  logic                   we_q;
  logic [1:0]             n_last;
  logic [1:0]             w_last;
  logic [1:0]             cnt;
  logic [1:0]             cnt_inc;
  logic                   rd_pend;
  logic [1:0]             rd_idx;
  logic                   mis;
  logic                   unused;

  assign unused    = ^{mem_addr, mem_wdata};
  assign cnt_inc   = cnt + 2'd1;
  assign mem_ready = (state == DONE);
  assign mem_rdata = M_WIDTH'(rdata_q);

  // Index of the last byte; the reserved code 2'b11 behaves as a byte access.
  always_comb begin
    w_last = 2'd0;
    unique case (1'b1)
      (mem_data_width == MEM_ACC_8):  w_last = 2'd0;
      (mem_data_width == MEM_ACC_16): w_last = 2'd1;
      (mem_data_width == MEM_ACC_32): w_last = 2'd3;
      default:                        w_last = 2'd0;
    endcase
  end

`ifdef MEM_BYTE_CTRL_ALIGN_CHECK_EN
  logic err_q;

  assign mis = ((w_last == 2'd1) && mem_addr[0]) ||
               ((w_last == 2'd3) && (mem_addr[1:0] != 2'b00));
  assign mem_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((state == IDLE) && mem_request) begin
      err_q <= mis;
    end else if ((state == DONE) && !mem_request) begin
      err_q <= 1'b0;
    end
  end
`else
  assign mis     = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (mem_request) begin
          state_nxt = mis ? DONE : XFER;
        end
      end
      XFER: begin
        if (cnt == n_last) begin
          state_nxt = we_q ? DONE : RDLAST;
        end
      end
      RDLAST: state_nxt = DONE;
      DONE: begin
        if (!mem_request) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM bus is registered; read bytes land one clock after their issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      a_lat     <= '0;
      wd_lat    <= '0;
      we_q      <= 1'b0;
      n_last    <= 2'd0;
      cnt       <= 2'd0;
      rd_pend   <= 1'b0;
      rd_idx    <= 2'd0;
      rdata_q   <= '0;
    end else begin
      rd_pend <= (state == XFER) && !we_q;
      rd_idx  <= cnt;
      if (rd_pend) begin
        rdata_q[{rd_idx, 3'b000} +: 8] <= ram_rdata;
      end
      unique case (state)
        IDLE: begin
          if (mem_request) begin
            a_lat  <= mem_addr[RAM_A_WIDTH-1:0];
            wd_lat <= mem_wdata[31:0];
            we_q   <= mem_we;
            n_last <= w_last;
            cnt    <= 2'd0;
            if (!mem_we) begin
              rdata_q <= '0;
            end
            if (!mis) begin
              ram_en    <= 1'b1;
              ram_we    <= mem_we;
              ram_addr  <= mem_addr[RAM_A_WIDTH-1:0];
              ram_wdata <= mem_wdata[7:0];
            end
          end
        end
        XFER: begin
          if (cnt == n_last) begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
          end else begin
            cnt       <= cnt_inc;
            ram_addr  <= a_lat + RAM_A_WIDTH'(cnt_inc);
            ram_wdata <= wd_lat[{cnt_inc, 3'b000} +: 8];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// tb_mem_byte_ctrl: vector table, corner sequences and random accesses vs a byte-array model.
// Expectations follow MEM_BYTE_CTRL_ALIGN_CHECK_EN when it is defined.
module tb_mem_byte_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_request;
  logic [31:0] mem_addr;
  logic [1:0]  mem_data_width;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        ram_en;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  mem_byte_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_request    (mem_request),
    .mem_addr       (mem_addr),
    .mem_data_width (mem_data_width),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .mem_err        (mem_err),
    .ram_en         (ram_en),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       we;
    logic [7:0] a;
    logic [7:0] d;
  } sram_cyc_t;

  logic [7:0] sram    [256];
  logic [7:0] ref_mem [256];
  logic [7:0] rd_q;
  sram_cyc_t  log_q[$];
  int         cyc;
  int         checks;
  int         failures;
  logic [31:0] last_rd;

  assign ram_rdata = rd_q;

  // Synchronous byte SRAM plus a log of every enabled cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) begin
      log_q.push_back('{cyc: cyc, we: ram_we, a: ram_addr, d: ram_wdata});
      if (ram_we) sram[ram_addr] <= ram_wdata;
      else rd_q <= sram[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int n_bytes(input logic [1:0] w);
    return (w == 2'b01) ? 2 : (w == 2'b10) ? 4 : 1;
  endfunction

  function automatic logic model_mis(input logic [31:0] a,
                                     input logic [1:0] w);
`ifdef MEM_BYTE_CTRL_ALIGN_CHECK_EN
    return ((w == 2'b01) && a[0]) || ((w == 2'b10) && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a,
                                             input int n);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < n; k++)
      r = r | (32'(ref_mem[(a + k) % 256]) << (8 * k));
    return r;
  endfunction

  // One access from IDLE; called and returning at a falling edge.
  task automatic run_acc(input logic [31:0] a, input logic [1:0] w,
                         input logic we, input logic [31:0] wd,
                         input int hold, output logic [31:0] rd,
                         output int lat, output logic err);
    log_q.delete();
    mem_addr       = a;
    mem_data_width = w;
    mem_we         = we;
    mem_wdata      = wd;
    mem_request    = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end while (!mem_ready && lat < 20);
    chk("ready_timeout", {31'b0, mem_ready}, 32'd1);
    rd  = mem_rdata;
    err = mem_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("ready_held", {31'b0, mem_ready}, 32'd1);
    end
    mem_request = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_drop", {31'b0, mem_ready}, 32'd0);
    chk("err_drop", {31'b0, mem_err}, 32'd0);
  endtask

  task automatic check_acc(input string tag, input logic [31:0] a,
                           input logic [1:0] w, input logic we,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int lat, input logic err,
                           input logic [31:0] exp_rd, input int exp_lat,
                           input logic exp_err);
    int   n;
    int   exp_en;
    logic m;
    n      = n_bytes(w);
    m      = model_mis(a, w);
    exp_en = m ? 0 : n;
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    chk({tag, "_en_cnt"}, log_q.size(), exp_en);
    for (int k = 0; k < exp_en && k < log_q.size(); k++) begin
      chk({tag, "_ram_addr"}, {24'b0, log_q[k].a}, (a + k) % 256);
      chk({tag, "_ram_we"}, {31'b0, log_q[k].we}, {31'b0, we});
      if (we) chk({tag, "_ram_wdata"}, {24'b0, log_q[k].d}, (wd >> (8 * k)) & 32'hFF);
      if (k > 0) chk({tag, "_consec"}, log_q[k].cyc - log_q[k-1].cyc, 1);
    end
    if (we && !m) begin
      for (int k = 0; k < n; k++) ref_mem[(a + k) % 256] = wd[8*k +: 8];
    end
    if (!we) last_rd = exp_rd;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [1:0]  w;
    logic        we;
    logic [31:0] wd;
    int          hold;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

`ifdef MEM_BYTE_CTRL_ALIGN_CHECK_EN
  localparam logic [31:0] MIS_RD  = 32'h0;
  localparam int          MIS_LAT = 1;
  localparam logic        MIS_ERR = 1'b1;
`else
  localparam logic [31:0] MIS_RD  = 32'h0000ADBE;
  localparam int          MIS_LAT = 4;
  localparam logic        MIS_ERR = 1'b0;
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[11];
    logic [31:0] rd;
    int          lat;
    logic        err;
    int          pulses;
    logic [31:0] seen;

    checks   = 0;
    failures = 0;
    cyc      = 0;
    last_rd  = 32'h0;
    rd_q     = 8'h0;
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 8'h0;
      ref_mem[i] = 8'h0;
    end

    vt[0]  = '{32'h10, 2'b10, 1'b1, 32'hDEADBEEF, 3, 32'h0, 5, 1'b0};
    vt[1]  = '{32'h10, 2'b10, 1'b0, 32'h0, 0, 32'hDEADBEEF, 6, 1'b0};
    vt[2]  = '{32'h12, 2'b00, 1'b0, 32'h0, 0, 32'h000000AD, 3, 1'b0};
    vt[3]  = '{32'h12, 2'b01, 1'b0, 32'h0, 1, 32'h0000DEAD, 4, 1'b0};
    vt[4]  = '{32'hFE, 2'b10, 1'b1, 32'h44332211, 0, 32'h0000DEAD, 5, 1'b0};
    vt[5]  = '{32'hFE, 2'b10, 1'b0, 32'h0, 0, 32'h44332211, 6, 1'b0};
    vt[6]  = '{32'h00, 2'b00, 1'b0, 32'h0, 0, 32'h00000033, 3, 1'b0};
    vt[7]  = '{32'h13, 2'b11, 1'b0, 32'h0, 0, 32'h000000DE, 3, 1'b0};
    vt[8]  = '{32'h11, 2'b01, 1'b0, 32'h0, 0, MIS_RD, MIS_LAT, MIS_ERR};
    vt[9]  = '{32'h20, 2'b00, 1'b1, 32'hFFFFFF5A, 0, MIS_RD, 2, 1'b0};
    vt[10] = '{32'h20, 2'b00, 1'b0, 32'h0, 0, 32'h0000005A, 3, 1'b0};

    rst_n          = 1'b0;
    mem_request    = 1'b0;
    mem_addr       = 32'h0;
    mem_data_width = 2'b00;
    mem_we         = 1'b0;
    mem_wdata      = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, mem_ready}, 32'd0);
    chk("rst_ram_en", {31'b0, ram_en}, 32'd0);
    chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("rst_ram_addr", {24'b0, ram_addr}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_err", {31'b0, mem_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while byte 1 of a word write is on the SRAM bus.
    mem_addr       = 32'h40;
    mem_data_width = 2'b10;
    mem_we         = 1'b1;
    mem_wdata      = 32'h0A0B0C0D;
    mem_request    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_byte1_addr", {24'b0, ram_addr}, 32'h41);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ram_en", {31'b0, ram_en}, 32'd0);
    chk("mid_rst_ram_we", {31'b0, ram_we}, 32'd0);
    mem_request = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", {31'b0, mem_ready}, 32'd0);
    chk("mid_rel_ram_en", {31'b0, ram_en}, 32'd0);
    chk("mid_byte0", {24'b0, sram[8'h40]}, 32'h0D);
    chk("mid_byte2", {24'b0, sram[8'h42]}, 32'h0);
    chk("mid_byte3", {24'b0, sram[8'h43]}, 32'h0);
    ref_mem[8'h40] = 8'h0D;

    for (int i = 0; i < 11; i++) begin
      run_acc(vt[i].a, vt[i].w, vt[i].we, vt[i].wd, vt[i].hold, rd, lat, err);
      check_acc($sformatf("vec%0d", i), vt[i].a, vt[i].w, vt[i].we,
                vt[i].wd, rd, lat, err, vt[i].exp_rd, vt[i].exp_lat,
                vt[i].exp_err);
    end

    // Request dropped mid-read: access completes, single ready pulse.
    log_q.delete();
    mem_addr       = 32'h10;
    mem_data_width = 2'b10;
    mem_we         = 1'b0;
    mem_request    = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    mem_request = 1'b0;
    pulses = 0;
    seen   = 32'h0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_ready) begin
        pulses++;
        seen = mem_rdata;
      end
    end
    chk("drop_pulses", pulses, 1);
    chk("drop_rdata", seen, 32'hDEADBEEF);
    chk("drop_en_cnt", log_q.size(), 4);
    last_rd = 32'hDEADBEEF;

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [1:0]  w;
      logic        we;
      logic [31:0] wd;
      logic        m;
      logic [31:0] erd;
      int          elat;
      a  = $urandom_range(0, 255);
      w  = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      m  = model_mis(a, w);
      if (m) elat = 1;
      else elat = we ? n_bytes(w) + 1 : n_bytes(w) + 2;
      if (we) erd = last_rd;
      else erd = m ? 32'h0 : model_read(a, n_bytes(w));
      run_acc(a, w, we, wd, $urandom_range(0, 2), rd, lat, err);
      check_acc($sformatf("rnd%0d", i), a, w, we, wd, rd, lat, err,
                erd, elat, m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
